// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: RISC-V funct3 values, memory
// port type codes and controller state encoding.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LBU = 3'b001;
  localparam logic [2:0] LT_LH  = 3'b010;
  localparam logic [2:0] LT_LHU = 3'b011;
  localparam logic [2:0] LT_LW  = 3'b100;
  localparam logic [1:0] ST_SB  = 2'b00;
  localparam logic [1:0] ST_SH  = 2'b01;
  localparam logic [1:0] ST_SW  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_RESP   = 2'b10
  } state_t;

endpackage

// File: rtl/lsu_mem_ctrl_decode.sv
// Combinational decode of a pipeline request into memory load/store type
// codes, flagging illegal opcodes and misaligned addresses.
module lsu_decode
  import lsu_pkg::*;
(
  input  logic       load,
  input  logic       store,
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lo,
  output logic [2:0] load_type,
  output logic [1:0] store_type,
  output logic       err
);

  logic illegal;
  logic misaligned;

  always_comb begin
    load_type  = LT_LB;
    store_type = ST_SB;
    illegal    = 1'b0;
    if (load == store) begin
      illegal = 1'b1;
    end else if (load) begin
      case (funct3)
        F3_LB:   load_type = LT_LB;
        F3_LH:   load_type = LT_LH;
        F3_LW:   load_type = LT_LW;
        F3_LBU:  load_type = LT_LBU;
        F3_LHU:  load_type = LT_LHU;
        default: illegal   = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_SB:   store_type = ST_SB;
        F3_SH:   store_type = ST_SH;
        F3_SW:   store_type = ST_SW;
        default: illegal    = 1'b1;
      endcase
    end
    // funct3[1:0] gives the access size for every legal load and store
    misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    err = illegal | misaligned;
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator for the byte-addressed data memory: one request per
// handshake, optional wait states, registered response with backpressure.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_load_i,
  input  logic              req_store_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_data_o,
  output logic              rsp_err_o,
  output logic              mem_rd_en_o,
  output logic              mem_wr_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wr_data_o,
  output logic [2:0]        mem_load_type_o,
  output logic [1:0]        mem_store_type_o,
  input  logic [31:0]       mem_rd_data_i
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic              load_reg;
  logic [2:0]        load_type_reg;
  logic [1:0]        store_type_reg;
  logic [31:0]       rsp_data_reg, rsp_data_next;
  logic              rsp_err_reg, rsp_err_next;
  logic              req_fire;

  logic [2:0]        dec_load_type;
  logic [1:0]        dec_store_type;
  logic              dec_err;

  lsu_decode u_decode (
    .load       (req_load_i),
    .store      (req_store_i),
    .funct3     (req_funct3_i),
    .addr_lo    (req_addr_i[1:0]),
    .load_type  (dec_load_type),
    .store_type (dec_store_type),
    .err        (dec_err)
  );

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    rsp_data_next = rsp_data_reg;
    rsp_err_next  = rsp_err_reg;
    req_fire      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (req_valid_i) begin
          req_fire      = 1'b1;
          rsp_data_next = 32'h0;
          rsp_err_next  = dec_err;
          cnt_next      = WAIT_INIT;
          state_next    = dec_err ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_reg == 4'd0) begin
          rsp_data_next = load_reg ? mem_rd_data_i : 32'h0;
          state_next    = S_RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= 4'd0;
      addr_reg       <= '0;
      wdata_reg      <= 32'h0;
      load_reg       <= 1'b0;
      load_type_reg  <= 3'b000;
      store_type_reg <= 2'b00;
      rsp_data_reg   <= 32'h0;
      rsp_err_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      rsp_data_reg <= rsp_data_next;
      rsp_err_reg  <= rsp_err_next;
      if (req_fire) begin
        addr_reg       <= req_addr_i;
        wdata_reg      <= req_wdata_i;
        load_reg       <= req_load_i;
        load_type_reg  <= dec_load_type;
        store_type_reg <= dec_store_type;
      end
    end
  end

  assign req_ready_o      = (state_reg == S_IDLE);
  assign rsp_valid_o      = (state_reg == S_RESP);
  assign rsp_data_o       = rsp_data_reg;
  assign rsp_err_o        = rsp_err_reg;
  assign mem_rd_en_o      = (state_reg == S_ACCESS) && load_reg;
  // Gated by rst so an abort on the final access cycle cannot commit a write
  assign mem_wr_en_o      = (state_reg == S_ACCESS) && !load_reg && (cnt_reg == 4'd0) && !rst;
  assign mem_addr_o       = addr_reg;
  assign mem_wr_data_o    = wdata_reg;
  assign mem_load_type_o  = load_type_reg;
  assign mem_store_type_o = store_type_reg;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: two instances (0 and 2 wait states),
// each with its own byte memory, checked against a byte-level reference model.
module tb_lsu_mem_ctrl;

  localparam int NI = 2;

  typedef struct {
    int          inst;
    logic        err;
    logic [31:0] data;
    int          first_cyc;
    int          rd_n;
    int          wr_n;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_clr;
  logic        req_valid   [NI];
  logic        req_ready   [NI];
  logic        req_load    [NI];
  logic        req_store   [NI];
  logic [2:0]  req_funct3  [NI];
  logic [7:0]  req_addr    [NI];
  logic [31:0] req_wdata   [NI];
  logic        rsp_valid   [NI];
  logic        rsp_ready   [NI];
  logic [31:0] rsp_data    [NI];
  logic        rsp_err     [NI];
  logic        mem_rd_en   [NI];
  logic        mem_wr_en   [NI];
  logic [7:0]  mem_addr    [NI];
  logic [31:0] mem_wr_data [NI];
  logic [2:0]  mem_load_type  [NI];
  logic [1:0]  mem_store_type [NI];

  logic [7:0]  ref_mem [NI][256];
  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wait_of(input int i);
    return (i == 0) ? 0 : 2;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    logic [7:0]  dmem [256];
    logic [31:0] rd_data;
    logic [7:0]  b0, b1, b2, b3;
    logic        seen;
    int          rd_cnt, wr_cnt, wr_cyc;

    lsu_mem_ctrl #(.ADDR_W(8), .WAIT_CYCLES(gi == 0 ? 0 : 2)) u_dut (
      .clk              (clk),
      .rst              (rst),
      .req_valid_i      (req_valid[gi]),
      .req_ready_o      (req_ready[gi]),
      .req_load_i       (req_load[gi]),
      .req_store_i      (req_store[gi]),
      .req_funct3_i     (req_funct3[gi]),
      .req_addr_i       (req_addr[gi]),
      .req_wdata_i      (req_wdata[gi]),
      .rsp_valid_o      (rsp_valid[gi]),
      .rsp_ready_i      (rsp_ready[gi]),
      .rsp_data_o       (rsp_data[gi]),
      .rsp_err_o        (rsp_err[gi]),
      .mem_rd_en_o      (mem_rd_en[gi]),
      .mem_wr_en_o      (mem_wr_en[gi]),
      .mem_addr_o       (mem_addr[gi]),
      .mem_wr_data_o    (mem_wr_data[gi]),
      .mem_load_type_o  (mem_load_type[gi]),
      .mem_store_type_o (mem_store_type[gi]),
      .mem_rd_data_i    (rd_data)
    );

    // Data memory: asynchronous extended read, byte-lane write on the clock
    always_comb begin
      b0 = dmem[mem_addr[gi]];
      b1 = dmem[mem_addr[gi] + 8'd1];
      b2 = dmem[mem_addr[gi] + 8'd2];
      b3 = dmem[mem_addr[gi] + 8'd3];
      case (mem_load_type[gi])
        3'd0:    rd_data = {{24{b0[7]}}, b0};
        3'd1:    rd_data = {24'h0, b0};
        3'd2:    rd_data = {{16{b1[7]}}, b1, b0};
        3'd3:    rd_data = {16'h0, b1, b0};
        default: rd_data = {b3, b2, b1, b0};
      endcase
    end

    always @(posedge clk) begin
      if (mem_clr) begin
        for (int k = 0; k < 256; k++) dmem[k] <= 8'h00;
      end else if (mem_wr_en[gi]) begin
        dmem[mem_addr[gi]] <= mem_wr_data[gi][7:0];
        if (mem_store_type[gi] != 2'b00) dmem[mem_addr[gi] + 8'd1] <= mem_wr_data[gi][15:8];
        if (mem_store_type[gi] == 2'b10) begin
          dmem[mem_addr[gi] + 8'd2] <= mem_wr_data[gi][23:16];
          dmem[mem_addr[gi] + 8'd3] <= mem_wr_data[gi][31:24];
        end
      end
    end

    // Monitor: strobe counting, latency and response checks against the queue head
    initial begin
      seen = 1'b0; rd_cnt = 0; wr_cnt = 0; wr_cyc = -1;
      forever begin
        @(negedge clk);
        if (mem_rd_en[gi] === 1'b1) rd_cnt++;
        if (mem_wr_en[gi] === 1'b1) begin wr_cnt++; wr_cyc = cyc; end
        if (rsp_valid[gi] === 1'b1) begin
          if (sb_q.size() == 0 || sb_q[0].inst != gi) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_rsp inst%0d: got rsp_valid=1, expected 0", gi);
          end else begin
            if (!seen) begin
              seen = 1'b1;
              check("latency", cyc, sb_q[0].first_cyc);
              check("rd_strobes", rd_cnt, sb_q[0].rd_n);
              check("wr_strobes", wr_cnt, sb_q[0].wr_n);
              if (sb_q[0].wr_n > 0) check("wr_cycle", wr_cyc, sb_q[0].first_cyc - 1);
            end
            check("rsp_data", rsp_data[gi], sb_q[0].data);
            check("rsp_err", rsp_err[gi], sb_q[0].err);
            check("ready_in_resp", req_ready[gi], 0);
            if (rsp_ready[gi]) begin
              void'(sb_q.pop_front());
              seen = 1'b0; rd_cnt = 0; wr_cnt = 0;
            end
          end
        end
      end
    end
  end

  // Reference model: legality and little-endian byte semantics from first principles
  task automatic model(input int i, input logic ld, input logic st, input logic [2:0] f3,
                       input logic [7:0] addr, input logic [31:0] wd, output exp_t e);
    int size;
    logic [31:0] v;
    e.inst = i; e.data = 32'h0; e.rd_n = 0; e.wr_n = 0; e.first_cyc = 0;
    e.err = (ld == st) || (ld && (f3 == 3 || f3 == 6 || f3 == 7)) || (st && f3 >= 3);
    size = 1 << f3[1:0];
    if (!e.err && (int'(addr) % size != 0)) e.err = 1'b1;
    if (e.err) return;
    if (ld) begin
      v = 32'h0;
      for (int b = 0; b < size; b++) v |= 32'(ref_mem[i][8'(int'(addr) + b)]) << (8 * b);
      if (!f3[2] && size < 4 && v[8 * size - 1]) v |= ~((32'h1 << (8 * size)) - 32'h1);
      e.data = v;
      e.rd_n = 1 + wait_of(i);
    end else begin
      for (int b = 0; b < size; b++) ref_mem[i][8'(int'(addr) + b)] = wd[8 * b +: 8];
      e.wr_n = 1;
    end
  endtask

  task automatic do_req(input int i, input logic ld, input logic st, input logic [2:0] f3,
                        input logic [7:0] addr, input logic [31:0] wd, input int stall);
    exp_t e;
    bit ok;
    model(i, ld, st, f3, addr, wd, e);
    req_load[i] = ld; req_store[i] = st; req_funct3[i] = f3;
    req_addr[i] = addr; req_wdata[i] = wd; req_valid[i] = 1'b1;
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_ready[i]) begin ok = 1; break; end
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL req_timeout inst%0d: got req_ready=0 for 50 cycles, expected 1", i);
      req_valid[i] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    e.first_cyc = cyc + (e.err ? 0 : 1 + wait_of(i));
    sb_q.push_back(e);
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rsp_valid[i]) begin ok = 1; break; end
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL rsp_timeout inst%0d: got rsp_valid=0 for 50 cycles, expected 1", i);
      sb_q.delete();
      return;
    end
    repeat (stall) @(posedge clk);
    @(posedge clk); #1;
    rsp_ready[i] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[i] = 1'b0;
    $display("[TB] inst%0d ld=%0d st=%0d f3=%0d addr=%02h wdata=%08h stall=%0d -> err=%0d data=%08h",
             i, ld, st, f3, addr, wd, stall, e.err, e.data);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_seen;
    int vld_seen;
    rst = 1'b1; mem_clr = 1'b1;
    for (int i = 0; i < NI; i++) begin
      req_valid[i] = 1'b0; req_load[i] = 1'b0; req_store[i] = 1'b0; req_funct3[i] = 3'b000;
      req_addr[i] = 8'h00; req_wdata[i] = 32'h0; rsp_ready[i] = 1'b0;
      for (int a = 0; a < 256; a++) ref_mem[i][a] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; mem_clr = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("rst_req_ready", req_ready[i], 1);
      check("rst_outputs", {rsp_valid[i], rsp_err[i], mem_rd_en[i], mem_wr_en[i],
                            mem_load_type[i], mem_store_type[i], mem_addr[i]}, 0);
      check("rst_rsp_data", rsp_data[i], 0);
      check("rst_wr_data", mem_wr_data[i], 0);
    end
    @(posedge clk); #1;

    // Zero wait states: store/load round trip and sub-word extension
    do_req(0, 0, 1, 3'b010, 8'h10, 32'hDEADBEEF, 0);
    do_req(0, 1, 0, 3'b010, 8'h10, 32'h0, 0);
    do_req(0, 1, 0, 3'b000, 8'h13, 32'h0, 0);
    do_req(0, 1, 0, 3'b100, 8'h13, 32'h0, 0);
    do_req(0, 1, 0, 3'b001, 8'h10, 32'h0, 0);
    do_req(0, 1, 0, 3'b101, 8'h12, 32'h0, 0);
    // Misaligned and illegal requests
    do_req(0, 1, 0, 3'b001, 8'h11, 32'h0, 0);
    do_req(0, 0, 1, 3'b010, 8'h12, 32'h11223344, 0);
    do_req(0, 1, 0, 3'b011, 8'h10, 32'h0, 0);
    do_req(0, 1, 1, 3'b010, 8'h10, 32'h55667788, 0);
    do_req(0, 0, 0, 3'b000, 8'h10, 32'h0, 0);
    do_req(0, 1, 0, 3'b010, 8'h10, 32'h0, 1);
    // Top-of-memory word with response backpressure
    do_req(0, 0, 1, 3'b010, 8'hFC, 32'h00000034, 0);
    do_req(0, 1, 0, 3'b010, 8'hFC, 32'h0, 2);

    // Two wait states
    do_req(1, 0, 1, 3'b010, 8'h40, 32'hCAFEF00D, 0);
    do_req(1, 1, 0, 3'b010, 8'h40, 32'h0, 0);
    do_req(1, 0, 1, 3'b010, 8'h20, 32'hA5A5A5A5, 0);

    // Store aborted by reset on its second access cycle
    wr_seen = 0; vld_seen = 0;
    req_load[1] = 1'b0; req_store[1] = 1'b1; req_funct3[1] = 3'b010;
    req_addr[1] = 8'h20; req_wdata[1] = 32'h12345678; req_valid[1] = 1'b1;
    @(negedge clk);
    check("abort_req_ready", req_ready[1], 1);
    @(posedge clk); #1; req_valid[1] = 1'b0;
    @(negedge clk); wr_seen += int'(mem_wr_en[1]);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk); wr_seen += int'(mem_wr_en[1]);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("abort_ready_after_rst", req_ready[1], 1);
    for (int k = 0; k < 5; k++) begin
      wr_seen += int'(mem_wr_en[1]);
      vld_seen += int'(rsp_valid[1]);
      @(negedge clk);
    end
    check("abort_wr_strobes", wr_seen, 0);
    check("abort_rsp_valid", vld_seen, 0);
    $display("[TB] inst1 SW addr=20 wdata=12345678 aborted by reset");
    @(posedge clk); #1;
    do_req(1, 1, 0, 3'b010, 8'h20, 32'h0, 0);

    // Randomized traffic near the top of memory on both instances
    for (int n = 0; n < 80; n++) begin
      int i, r;
      logic ld, st;
      i = n % NI;
      r = $urandom_range(0, 9);
      ld = (r < 5) || (r == 9 && $urandom_range(0, 1) == 1);
      st = (r >= 5 && r < 9) || (r == 9 && ld);
      do_req(i, ld, st, 3'($urandom_range(0, 7)), 8'($urandom_range(224, 255)),
             $urandom, $urandom_range(0, 3));
    end

    repeat (4) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store initiator that drives the byte-addressed data memory port (rd_en/wr_en, addr, load_type, store_type, wr_data; asynchronous read data back) on behalf of the pipeline MEM stage. Accepts one request per valid/ready handshake, decodes RISC-V funct3 into the memory's load/store type codes, and traps misaligned or illegal accesses before they reach memory. Models a configurable number of memory wait states and returns a registered response with valid/ready backpressure.

Parameters:
ADDR_W, 8, byte-address width of the memory port
WAIT_CYCLES, 0, extra cycles held in ACCESS before sampling or writing (0..15)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
req_valid_i  in  1  pipeline request valid
req_ready_o  out  1  controller can accept a request
req_load_i  in  1  request is a load
req_store_i  in  1  request is a store
req_funct3_i  in  3  RISC-V funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
req_addr_i  in  ADDR_W  byte address
req_wdata_i  in  32  store data, unaligned to lane
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  pipeline accepts response
rsp_data_o  out  32  load result (extended by memory); 0 for stores and errors
rsp_err_o  out  1  misaligned or illegal access; no memory side effect
mem_rd_en_o  out  1  memory read enable
mem_wr_en_o  out  1  memory write enable
mem_addr_o  out  ADDR_W  memory byte address
mem_wr_data_o  out  32  memory write data
mem_load_type_o  out  3  000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW
mem_store_type_o  out  2  00 SB, 01 SH, 10 SW
mem_rd_data_i  in  32  asynchronous read data from memory

Behaviour:
- States: IDLE, ACCESS, RESP. req_ready_o = (state==IDLE); rsp_valid_o = (state==RESP).
- Reset (rst high at edge): state IDLE, wait counter 0, captured request/response regs 0. After reset: req_ready_o=1, all other outputs 0.
- mem_wr_en_o forced 0 in any cycle rst is high; this prevents a write at the reset edge.
- IDLE, handshake (req_valid_i & req_ready_o): capture addr, wdata, load/store flag, and decoded types.
  - Error conditions: load and store both set or both clear; load funct3 in {011,110,111}; store funct3 >= 011; halfword with addr[0]=1; word with addr[1:0]!=0.
  - On error: go to RESP with rsp_err_o=1 and rsp_data_o=0. No memory strobe is ever asserted.
  - Otherwise: go to ACCESS with counter = WAIT_CYCLES.
- ACCESS:
  - mem_addr_o, type outputs and mem_wr_data_o are driven from captured registers.
  - Load: mem_rd_en_o=1 for every ACCESS cycle.
  - Store: mem_wr_en_o=1 only in the cycle counter==0, so exactly one write per store.
  - Counter decrements each cycle. When counter==0: a load latches mem_rd_data_i into rsp_data_o, a store sets rsp_data_o=0; then go to RESP.
  - ACCESS lasts WAIT_CYCLES+1 cycles.
- Outside ACCESS: mem_rd_en_o=0, mem_wr_en_o=0, mem_addr_o/types/wr_data hold their last captured values.
- RESP: rsp_valid_o, rsp_data_o and rsp_err_o stay stable until rsp_ready_i. On rsp_valid_o & rsp_ready_i, go to IDLE with no bubble-free accept; the next request is accepted the following cycle.
- Latency: request accepted at edge N → rsp_valid_o high from cycle N+2+WAIT_CYCLES (error path: from cycle N+1).
- req_valid_i while not ready is ignored. The requester must hold it.
- Boundary cases:
  - LW at the last aligned word (0xFC for ADDR_W=8) is legal.
  - Any access crossing the top of memory is already rejected by the alignment check.
- Reset mid-operation: abort, no write, no response; IDLE next cycle.

Decomposition:
- Package lsu_pkg:
  - funct3 constants (F3_LB..F3_SW)
  - memory type codes (LT_LB, LT_LBU, LT_LH, LT_LHU, LT_LW, ST_SB, ST_SH, ST_SW)
  - state encoding (S_IDLE, S_ACCESS, S_RESP)
- Sub-module lsu_decode (combinational): funct3 + load/store + addr[1:0] → load_type, store_type, err.
- lsu_mem_ctrl holds the FSM, counter, capture and response registers.

Test Plan:
- Store then load, WAIT_CYCLES=0, with data_mem attached:
  - SW addr 0x10 data 0xDEADBEEF → mem_wr_en_o high exactly 1 cycle, store_type 10; rsp_valid at N+2 with data 0, err 0.
  - Then LW 0x10 → rsp_data_o 0xDEADBEEF.
- Byte loads after the above:
  - LB 0x13 → 0xFFFFFFDE.
  - LBU 0x13 → 0x000000DE.
  - LH 0x10 → 0xFFFFBEEF.
  - LHU 0x12 → 0x0000DEAD.
- Misaligned/illegal:
  - LH 0x11, SW 0x12, and load funct3 011 → each rsp_err_o=1 at N+1, rsp_data_o=0, no rd/wr strobe.
  - Word at 0x10 unchanged.
- Backpressure: LW 0xFC on preloaded memory (0xFC=0x34, 0xFD..0xFF=0), rsp_ready_i low 3 cycles → rsp_valid_o held with 0x00000034 stable, req_ready_o=0 throughout.
- Wait states, WAIT_CYCLES=2: LW → mem_rd_en_o high 3 cycles, rsp_valid_o at N+4. SW → single wr_en pulse in the 3rd ACCESS cycle.
- Reset mid-op, WAIT_CYCLES=2: SW 0x20 data 0x12345678, rst asserted on the 2nd ACCESS cycle → mem_wr_en_o never 1, mem[0x20..0x23] unchanged, no rsp_valid_o, req_ready_o=1 next cycle.
